// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, R-type functs, FSM states
// and ALU operations.
package cpu_pkg;

    localparam logic [7:0] OP_RTYPE = 8'h00;
    localparam logic [7:0] OP_ADDI  = 8'h01;
    localparam logic [7:0] OP_LW    = 8'h02;
    localparam logic [7:0] OP_SW    = 8'h03;
    localparam logic [7:0] OP_BEQ   = 8'h04;
    localparam logic [7:0] OP_BNE   = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_SLT = 4'd4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic logic funct_legal(input logic [3:0] funct);
        return funct <= FN_SLT;
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [3:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Memory port of the multicycle CPU: one request/ready handshake carrying
// fetches, loads and stores of 32-bit big-endian words.
interface multicycle_cpu_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub/and/or/signed set-less-than, plus an operand
// equality flag used for branch resolution.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        eq
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end

    assign eq = (a == b);

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle 32-bit CPU with a 16-entry register file and one shared memory
// port; each instruction walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB].
//
// state     | meaning
// ST_FETCH  | request word at pc; on ready latch IR, pc += 4
// ST_DECODE | latch A = reg[rs], B = reg[rt]
// ST_EXEC   | resolve branch/jump/halt/illegal, else route to MEM or WB
// ST_MEM    | load/store at A + imm; on ready latch MDR (lw)
// ST_WB     | single register-file write
// ST_HALT   | parked until reset, no bus activity
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                ZERO_R0  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_cpu_if.master  mem,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] dbg_pc
);

    state_t            state, state_next;
    logic              run;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [31:0]       ir, a_q, b_q, mdr;
    logic [31:0]       regs [16];
    logic              illegal_q;

    logic [7:0]  opcode;
    logic [3:0]  rs, rt, rd, funct;
    logic [31:0] imm_x, jt_x, br_off;

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_y;
    logic        alu_eq;

    logic        req, handshake;
    logic        ir_ld, ab_ld, mdr_ld, pc_ld, rf_we, ill_set;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;

    assign opcode = ir[31:24];
    assign rs     = ir[23:20];
    assign rt     = ir[19:16];
    assign rd     = ir[15:12];
    assign funct  = ir[3:0];
    assign imm_x  = {{16{ir[15]}}, ir[15:0]};
    assign jt_x   = {{8{ir[23]}}, ir[23:0]};
    assign br_off = {imm_x[29:0], 2'b00};

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            alu_op = funct_to_alu(funct);
        end
    end

    assign alu_b = (opcode == OP_RTYPE || opcode == OP_BEQ || opcode == OP_BNE) ? b_q : imm_x;

    cpu_alu u_alu (
        .op (alu_op),
        .a  (a_q),
        .b  (alu_b),
        .y  (alu_y),
        .eq (alu_eq)
    );

    // run holds the bus quiet for the reset cycle so FETCH can be the reset state
    assign req       = run && (state == ST_FETCH || state == ST_MEM);
    assign handshake = req && mem.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pc_ld      = 1'b0;
        ir_ld      = 1'b0;
        ab_ld      = 1'b0;
        mdr_ld     = 1'b0;
        rf_we      = 1'b0;
        ill_set    = 1'b0;
        case (state)
            ST_FETCH: begin
                if (handshake) begin
                    ir_ld      = 1'b1;
                    pc_ld      = 1'b1;
                    pc_next    = pc + ADDR_W'(4);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ab_ld      = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_legal(funct)) begin
                            state_next = ST_WB;
                        end else begin
                            ill_set    = 1'b1;
                            state_next = ST_HALT;
                        end
                    end
                    OP_ADDI:      state_next = ST_WB;
                    OP_LW, OP_SW: state_next = ST_MEM;
                    OP_BEQ, OP_BNE: begin
                        if (alu_eq == (opcode == OP_BEQ)) begin
                            pc_ld   = 1'b1;
                            pc_next = pc + br_off[ADDR_W-1:0];
                        end
                        state_next = ST_FETCH;
                    end
                    OP_J: begin
                        pc_ld      = 1'b1;
                        pc_next    = jt_x[ADDR_W-1:0];
                        state_next = ST_FETCH;
                    end
                    OP_HALT: state_next = ST_HALT;
                    default: begin
                        ill_set    = 1'b1;
                        state_next = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (handshake) begin
                    if (opcode == OP_LW) begin
                        mdr_ld     = 1'b1;
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            pc        <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mdr       <= '0;
            illegal_q <= 1'b0;
        end else begin
            run <= 1'b1;
            if (pc_ld) begin
                pc <= pc_next;
            end
            if (ir_ld) begin
                ir <= mem.mem_rdata;
            end
            if (ab_ld) begin
                a_q <= regs[rs];
                b_q <= regs[rt];
            end
            if (mdr_ld) begin
                mdr <= mem.mem_rdata;
            end
            if (ill_set) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign wr_idx  = (opcode == OP_RTYPE) ? rd : rt;
    assign wr_data = (opcode == OP_LW) ? mdr : alu_y;

    // r0 is never written when hard-wired, so reads of regs[0] stay zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && !(ZERO_R0 && wr_idx == 4'd0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = req && (state == ST_MEM) && (opcode == OP_SW);
    assign mem.mem_addr  = (state == ST_MEM) ? alu_y[ADDR_W-1:0] : pc;
    assign mem.mem_wdata = (req && state == ST_MEM) ? b_q : '0;

    assign halted  = (state == ST_HALT);
    assign illegal = illegal_q;
    assign dbg_pc  = pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: programs in a behavioural memory with
// per-address wait states, plus a second instance with a writable r0.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_cpu_if #(.ADDR_W(AW)) bus ();
    multicycle_cpu_if #(.ADDR_W(AW)) bus2 ();

    logic          halted, illegal, halted2, illegal2;
    logic [AW-1:0] dbg_pc, dbg_pc2;

    multicycle_cpu #(.ADDR_W(AW), .RESET_PC(8'h00), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus),
        .halted(halted), .illegal(illegal), .dbg_pc(dbg_pc)
    );

    multicycle_cpu #(.ADDR_W(AW), .RESET_PC(8'h00), .ZERO_R0(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem(bus2),
        .halted(halted2), .illegal(illegal2), .dbg_pc(dbg_pc2)
    );

    // main memory: word array plus a one-entry store shadow
    logic [31:0]   mem [64];
    logic          slow_en;
    logic [AW-1:0] slow_addr;
    int            slow_wait;
    int            wait_cnt;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    int            st_count;
    int            cyc;

    always_comb begin
        bus.mem_ready = bus.mem_req &&
                        (!slow_en || bus.mem_addr != slow_addr || wait_cnt >= slow_wait);
        bus.mem_rdata = (st_valid && st_addr == bus.mem_addr) ? st_data : mem[bus.mem_addr[7:2]];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            st_valid <= 1'b0;
            st_addr  <= '0;
            st_data  <= '0;
            st_count <= 0;
        end else begin
            if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
            else                                wait_cnt <= 0;
            if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
                st_valid <= 1'b1;
                st_addr  <= bus.mem_addr;
                st_data  <= bus.mem_wdata;
                st_count <= st_count + 1;
            end
        end
    end

    always_comb begin
        bus2.mem_ready = bus2.mem_req;
        case (bus2.mem_addr[3:2])
            2'd0:    bus2.mem_rdata = 32'h0100_0007;
            2'd1:    bus2.mem_rdata = 32'h0103_0001;
            default: bus2.mem_rdata = 32'hFF00_0000;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;
    initial cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic start_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        slow_en = 1'b0;
        slow_addr = '0;
        slow_wait = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input logic [AW-1:0] a, output int stamp, output bit found);
        found = 1'b0;
        stamp = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_we && bus.mem_addr == a) begin
                found = 1'b1;
                stamp = cyc;
            end
        end
    endtask

    task automatic next_req(output logic [AW-1:0] a, output int stamp, output bit found);
        bit done = 1'b0;
        found = 1'b0;
        stamp = 0;
        a     = '0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (bus.mem_req && bus.mem_ready) done = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        for (int i = 0; i < 300 && !found && done; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                found = 1'b1;
                a     = bus.mem_addr;
                stamp = cyc;
            end
        end
    endtask

    task automatic wait_halt(output bit found);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        start_reset();
        mem[0] = 32'h0101_0005;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: req=%b we=%b wdata=%h, required 0 0 0",
                     bus.mem_req, bus.mem_we, bus.mem_wdata);
        end
        n_checks++;
        if (halted !== 1'b0 || illegal !== 1'b0 || dbg_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_status: halted=%b illegal=%b pc=%h, required 0 0 00",
                     halted, illegal, dbg_pc);
        end
        release_reset();
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_quiet: req=%b, required 0 before first edge", bus.mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_first_fetch: req=%b we=%b addr=%h, required 1 0 00",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
    endtask

    task automatic test_addi();
        int t0, t1;
        bit f0, f1;
        logic [AW-1:0] a;
        start_reset();
        mem[0] = 32'h0101_0005;
        mem[1] = 32'hFF00_0000;
        release_reset();
        wait_req(8'h00, t0, f0);
        next_req(a, t1, f1);
        n_checks++;
        if (!f0 || !f1 || a !== 8'h04 || (t1 - t0) != 4) begin
            n_fail++;
            $display("FAIL addi_timing: found=%b%b next=%h cycles=%0d, required 04 after 4",
                     f0, f1, a, t1 - t0);
        end
        n_checks++;
        if (dut.regs[1] !== 32'h5) begin
            n_fail++;
            $display("FAIL addi_r1: got %h, required 00000005", dut.regs[1]);
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog [9];
        logic [31:0] exp_r [9];
        bit f;
        prog = '{32'h0101_0005, 32'h0102_FFFD, 32'h0012_3000, 32'h0012_4001, 32'h0012_5002,
                 32'h0012_6003, 32'h0021_7004, 32'h0012_8004, 32'hFF00_0000};
        exp_r = '{32'h0, 32'h5, 32'hFFFF_FFFD, 32'h2, 32'h8, 32'h5,
                  32'hFFFF_FFFD, 32'h1, 32'h0};
        start_reset();
        for (int i = 0; i < 9; i++) mem[i] = prog[i];
        release_reset();
        wait_halt(f);
        n_checks++;
        if (!f || illegal !== 1'b0 || dbg_pc !== 8'h24) begin
            n_fail++;
            $display("FAIL alu_halt: halted=%b illegal=%b pc=%h, required 1 0 24", f, illegal, dbg_pc);
        end
        for (int r = 1; r < 9; r++) begin
            n_checks++;
            if (dut.regs[r] !== exp_r[r]) begin
                n_fail++;
                $display("FAIL alu_r%0d: got %h, required %h", r, dut.regs[r], exp_r[r]);
            end
        end
    endtask

    task automatic test_store_load();
        int t0, t1, waits;
        bit f0, f1, found, stable;
        start_reset();
        slow_en   = 1'b1;
        slow_addr = 8'h08;
        slow_wait = 3;
        mem[0]  = 32'h0600_0040;
        mem[12] = 32'h1234_5678;
        mem[16] = 32'h0201_0030;
        mem[17] = 32'h0301_0008;
        mem[18] = 32'h0202_0008;
        mem[19] = 32'hFF00_0000;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_we) found = 1'b1;
        end
        stable = 1'b1;
        waits  = 0;
        while (found && !bus.mem_ready && waits < 50) begin
            if (bus.mem_addr !== 8'h08 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h1234_5678)
                stable = 1'b0;
            waits++;
            @(negedge clk);
        end
        n_checks++;
        if (!found || !stable || waits != 3 || bus.mem_addr !== 8'h08 ||
            bus.mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL sw_hold: found=%b stable=%b waits=%0d addr=%h wdata=%h, required 1 1 3 08 12345678",
                     found, stable, waits, bus.mem_addr, bus.mem_wdata);
        end
        wait_req(8'h48, t0, f0);
        wait_req(8'h4C, t1, f1);
        n_checks++;
        if (!f0 || !f1 || (t1 - t0) != 8) begin
            n_fail++;
            $display("FAIL lw_cycles: found=%b%b cycles=%0d, required 8", f0, f1, t1 - t0);
        end
        wait_halt(f0);
        n_checks++;
        if (dut.regs[2] !== 32'h1234_5678 || st_count != 1 || st_addr !== 8'h08) begin
            n_fail++;
            $display("FAIL lw_data: r2=%h stores=%0d at %h, required 12345678 1 08",
                     dut.regs[2], st_count, st_addr);
        end
        n_checks++;
        if (!f0 || illegal !== 1'b0 || dbg_pc !== 8'h50) begin
            n_fail++;
            $display("FAIL halt_op: halted=%b illegal=%b pc=%h, required 1 0 50", f0, illegal, dbg_pc);
        end
    endtask

    task automatic test_branch();
        logic [31:0]   instr [4];
        logic [AW-1:0] target [4];
        int t0, t1;
        bit f0, f1;
        logic [AW-1:0] a;
        instr  = '{32'h0411_0002, 32'h0511_0002, 32'h0600_0040, 32'h0400_FFFC};
        target = '{8'h1C, 8'h14, 8'h40, 8'h04};
        for (int k = 0; k < 4; k++) begin
            start_reset();
            mem[0] = 32'h0600_0010;
            mem[4] = instr[k];
            release_reset();
            wait_req(8'h10, t0, f0);
            next_req(a, t1, f1);
            n_checks++;
            if (!f0 || !f1 || a !== target[k] || (t1 - t0) != 3) begin
                n_fail++;
                $display("FAIL branch_%0d: next=%h cycles=%0d, required %h after 3",
                         k, a, t1 - t0, target[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int t0, t1;
        bit f0, f1;
        logic [AW-1:0] a;
        start_reset();
        mem[0]  = 32'h06FF_FFFC;
        mem[63] = 32'h0101_0001;
        release_reset();
        wait_req(8'hFC, t0, f0);
        next_req(a, t1, f1);
        n_checks++;
        if (!f0 || !f1 || a !== 8'h00 || dbg_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL pc_wrap: found=%b%b next=%h pc=%h, required 00 00", f0, f1, a, dbg_pc);
        end
    endtask

    task automatic test_illegal();
        bit f;
        int busy;
        start_reset();
        mem[0] = 32'h0600_0020;
        mem[8] = 32'h7E00_0000;
        release_reset();
        wait_halt(f);
        n_checks++;
        if (!f || illegal !== 1'b1 || dbg_pc !== 8'h24) begin
            n_fail++;
            $display("FAIL illegal_op: halted=%b illegal=%b pc=%h, required 1 1 24", f, illegal, dbg_pc);
        end
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b0 || halted !== 1'b1 || dbg_pc !== 8'h24) busy++;
        end
        n_checks++;
        if (busy != 0) begin
            n_fail++;
            $display("FAIL halt_quiet: %0d active cycles, required 0", busy);
        end
        start_reset();
        mem[0] = 32'h0012_3005;
        release_reset();
        wait_halt(f);
        n_checks++;
        if (!f || illegal !== 1'b1 || dbg_pc !== 8'h04 || dut.regs[3] !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_funct: halted=%b illegal=%b pc=%h r3=%h, required 1 1 04 0",
                     f, illegal, dbg_pc, dut.regs[3]);
        end
    endtask

    task automatic test_reset_mid_store();
        bit found;
        start_reset();
        slow_en   = 1'b1;
        slow_addr = 8'h08;
        slow_wait = 20;
        mem[0] = 32'h0101_0055;
        mem[1] = 32'h0301_0008;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req && bus.mem_we) found = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_bus: found=%b req=%b we=%b wdata=%h, required 1 0 0 0",
                     found, bus.mem_req, bus.mem_we, bus.mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (st_count != 0 || dut.regs[1] !== 32'h0 || dbg_pc !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_state: stores=%0d r1=%h pc=%h, required 0 0 00",
                     st_count, dut.regs[1], dbg_pc);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_refetch: req=%b we=%b addr=%h, required 1 0 00",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
    endtask

    task automatic test_zero_r0();
        bit f;
        start_reset();
        mem[0] = 32'h0100_0007;
        mem[1] = 32'h0103_0001;
        mem[2] = 32'hFF00_0000;
        release_reset();
        wait_halt(f);
        n_checks++;
        if (!f || dut.regs[0] !== 32'h0 || dut.regs[3] !== 32'h1) begin
            n_fail++;
            $display("FAIL zero_r0_on: halted=%b r0=%h r3=%h, required 1 0 1",
                     f, dut.regs[0], dut.regs[3]);
        end
        n_checks++;
        if (halted2 !== 1'b1 || dut2.regs[0] !== 32'h7 || dut2.regs[3] !== 32'h8) begin
            n_fail++;
            $display("FAIL zero_r0_off: halted=%b r0=%h r3=%h, required 1 7 8",
                     halted2, dut2.regs[0], dut2.regs[3]);
        end
    endtask

    initial begin
        slow_en   = 1'b0;
        slow_addr = '0;
        slow_wait = 0;
        test_reset();
        test_addi();
        test_alu();
        test_store_load();
        test_branch();
        test_wrap();
        test_illegal();
        test_reset_mid_store();
        test_zero_r0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: byte-address width of the memory port.
REQ-002 The block SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-003 The block SHALL have parameter ZERO_R0, default 1: when 1, register 0 reads as 0 and ignores writes.
REQ-004 The block SHALL have input clk, 1 bit: single clock, all state on its rising edge.
REQ-005 The block SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have output mem_req, 1 bit: memory request valid.
REQ-007 The block SHALL have output mem_we, 1 bit: 1 = store, 0 = load or fetch.
REQ-008 The block SHALL have output mem_addr, ADDR_W bits: byte address of a 32-bit big-endian word.
REQ-009 The block SHALL have output mem_wdata, 32 bits: store data.
REQ-010 The block SHALL have input mem_rdata, 32 bits: read data, valid in the mem_ready cycle.
REQ-011 The block SHALL have input mem_ready, 1 bit: completes the current request.
REQ-012 The block SHALL have outputs halted (1 bit), illegal (1 bit, sticky) and dbg_pc (ADDR_W bits, current PC).

Function
REQ-013 Fields SHALL be: opcode=[31:24], rs=[23:20], rt=[19:16], rd=[15:12], funct=[3:0], imm=[15:0] sign-extended, jtarget=[23:0] sign-extended, used as an absolute byte address.
REQ-014 Opcodes SHALL be: 0x00 R-type, 0x01 addi, 0x02 lw, 0x03 sw, 0x04 beq, 0x05 bne, 0x06 j, 0xFF halt.
REQ-015 R-type funct SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1/0); the result is written to rd.
REQ-016 addi and lw SHALL write rt; lw/sw address SHALL be rs+imm truncated to ADDR_W; sw data SHALL be rt.
REQ-017 Any other opcode or R-type funct SHALL set illegal and enter HALT; the PC SHALL stay at pc+4 of that instruction.
REQ-018 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT; reset enters FETCH.
REQ-019 In FETCH the block SHALL drive mem_req=1, mem_we=0, mem_addr=pc; on mem_ready it SHALL latch IR, set pc=pc+4 and go to DECODE.
REQ-020 In DECODE the block SHALL latch A=reg[rs] and B=reg[rt], then go to EXEC.
REQ-021 In EXEC the block SHALL resolve instructions as follows:
- beq/bne: pc += imm<<2 when taken (A==B / A!=B), then FETCH.
- j: pc = jtarget, then FETCH.
- halt: go to HALT.
- lw/sw: go to MEM.
- R-type/addi: go to WB.
REQ-022 In MEM the block SHALL drive mem_req=1 with mem_addr=ALU result, mem_we=1 for sw, mem_wdata=B; on mem_ready, lw SHALL latch MDR and go to WB, and sw SHALL go to FETCH.
REQ-023 In WB the block SHALL write the register file once, then go to FETCH.
REQ-024 While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata SHALL hold stable; mem_ready SHALL be ignored when mem_req=0.
REQ-025 With zero-wait memory, cycle counts SHALL be R/addi 4, lw 5, sw 4, beq/bne/j 3; each wait cycle SHALL add exactly one cycle.
REQ-026 In HALT the block SHALL hold halted=1 and mem_req=0, make no register or PC changes, and remain there until reset.
REQ-027 PC arithmetic SHALL wrap modulo 2^ADDR_W, and mem_addr SHALL be the low ADDR_W bits.
REQ-028 mem_we and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-029 Asserting rst_n=0 SHALL, immediately and in any state (including mid-handshake), set:
- pc=RESET_PC, state=FETCH;
- all registers, IR, A, B and MDR to 0;
- mem_req=0, mem_we=0, mem_wdata=0, halted=0, illegal=0.
REQ-030 The first fetch request SHALL be asserted in the first clk edge cycle after rst_n rises.

Structure
REQ-031 A shared package cpu_pkg SHALL hold the opcode and funct constants, the FSM state enum and the ALU operation encoding.
REQ-032 A combinational sub-module cpu_alu SHALL implement add/sub/and/or/slt and the equality flag; the register file SHALL stay inside multicycle_cpu.

Verification
REQ-033 Reset, r1=0, mem at 0 = addi r1,r0,5 (0x01010005), zero-wait -> r1=5 after 4 cycles; next fetch address = 4.
REQ-034 sw r1,8(r0) then lw r2,8(r0) with r1=0x12345678, mem_ready delayed 3 cycles on each -> mem_addr stable during the waits, r2=0x12345678, the lw takes 8 cycles.
REQ-035 beq r1,r1,+2 at pc 0x10 -> next fetch at 0x1C; bne r1,r1,+2 at pc 0x10 -> next fetch at 0x14; j 0x000040 -> next fetch at 0x40.
REQ-036 Opcode 0x7E at pc 0x20 -> illegal=1, halted=1, dbg_pc=0x24, mem_req stays 0 for 20 cycles.
REQ-037 rst_n pulled low during a MEM wait of sw -> no write completes, mem_req drops the same cycle, and after release the fetch is at RESET_PC.
REQ-038 ZERO_R0=1 with addi r0,r0,7 -> r0 reads 0; with ZERO_R0=0 -> r0 reads 7.
